// File: rtl/data_mem_bytelane.sv
// Byte-addressed single-port data memory with RV32I load/store widths, byte-lane
// writes, 1-cycle registered responses, error flagging and an optional post-reset clear sweep.
module data_mem_bytelane #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter bit          INIT_CLEAR  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  typedef enum logic {
    ST_INIT,
    ST_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ready_q, ready_d;
  logic          done_q, done_d;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q, resp_rdata_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          accept;
  logic [AW-1:0] word_idx;
  logic [1:0]    lane;
  logic [1:0]    size;
  logic          out_of_range;
  logic          f3_ok;
  logic          misalign;
  logic          err;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_lanes;
  logic [31:0]   rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   load_data;

  assign accept       = req_valid & ready_q;
  assign word_idx     = req_addr[AW+1:2];
  assign lane         = req_addr[1:0];
  assign size         = req_funct3[1:0];
  assign out_of_range = |req_addr[31:AW+2];

  // Request legality: width/alignment and the funct3 encodings valid for each direction.
  always_comb begin
    if (req_we) begin
      f3_ok = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    end else begin
      f3_ok = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
    end
    misalign = ((size == 2'b01) && lane[0]) || ((size == 2'b10) && (lane != 2'b00));
    err      = out_of_range || !f3_ok || misalign;
  end

  // Store lane enables with write data replicated so each lane sees its own byte.
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = req_wdata;
    case (size)
      2'b00: begin
        byte_en     = 4'b0001 << lane;
        wdata_lanes = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        byte_en     = lane[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{req_wdata[15:0]}};
      end
      default: begin
        byte_en     = 4'b1111;
        wdata_lanes = req_wdata;
      end
    endcase
  end

  always_comb begin
    rd_word = mem_q[word_idx];
    case (lane)
      2'b00:   rd_byte = rd_word[7:0];
      2'b01:   rd_byte = rd_word[15:8];
      2'b10:   rd_byte = rd_word[23:16];
      default: rd_byte = rd_word[31:24];
    endcase
    rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_funct3)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'h0, rd_byte};
      3'b101:  load_data = {16'h0, rd_half};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    done_d  = done_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        ready_d = 1'b1;
        done_d  = 1'b1;
      end
    endcase
  end

  // rdata only changes on a response so it holds between responses.
  always_comb begin
    resp_rdata_d = resp_rdata_q;
    if (accept) begin
      resp_rdata_d = (err || req_we) ? '0 : load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= INIT_CLEAR ? ST_INIT : ST_IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      done_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      done_q       <= done_d;
      resp_valid_q <= accept;
      resp_err_q   <= accept & err;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  // Storage is not reset; the clear sweep and accepted legal stores are its only writers.
  always_ff @(posedge clk) begin
    if (INIT_CLEAR && (state_q == ST_INIT)) begin
      mem_q[cnt_q] <= '0;
    end else if (accept && req_we && !err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_q[word_idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
        end
      end
    end
  end

  assign req_ready  = ready_q;
  assign init_done  = done_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Randomized self-checking bench for data_mem_bytelane against a byte-array reference model.
module tb_data_mem_bytelane;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned NBYTES = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [7:0]  ref_mem [NBYTES];

  always #5 clk = ~clk;

  data_mem_bytelane #(.DEPTH_WORDS(DEPTH), .INIT_CLEAR(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .init_done  (init_done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: memory as a flat byte array, accesses as little-endian byte runs.
  function automatic void model_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata, output logic err, output logic [31:0] rd);
    int unsigned nb;
    logic legal;
    logic [31:0] v;
    nb = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    err = (addr >= NBYTES) || !legal || (legal && (addr % nb) != 0);
    rd = '0;
    if (!err) begin
      if (we) begin
        for (int unsigned i = 0; i < nb; i++) ref_mem[addr + i] = 8'(wdata >> (8 * i));
      end else begin
        v = '0;
        for (int unsigned i = 0; i < nb; i++) v = v | (32'(ref_mem[addr + i]) << (8 * i));
        if (!f3[2] && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rd = v;
      end
    end
  endfunction

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got);
    logic e;
    logic [31:0] r;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    check_eq("ready_at_req", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_req(we, f3, addr, wdata, e, r);
    check_eq("resp_valid", 32'(resp_valid), 32'd1);
    check_eq("resp_err", 32'(resp_err), 32'(e));
    check_eq("resp_rdata", resp_rdata, r);
    got = resp_rdata;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("no_resp_when_idle", 32'(resp_valid), 32'd0);
  endtask

  task automatic release_and_count(input int unsigned abort_at, output int unsigned n);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int unsigned k = 0; k < 600; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (abort_at != 0 && n == abort_at) break;
      if (req_ready) break;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
    check_eq({tag, "_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_rdata"}, resp_rdata, 32'd0);
    check_eq({tag, "_err"}, 32'(resp_err), 32'd0);
    check_eq({tag, "_done"}, 32'(init_done), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    int unsigned n;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr;

    for (int unsigned i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");

    release_and_count(0, n);
    check_eq("sweep_cycles", n, 32'd256);
    check_eq("init_done_after_sweep", 32'(init_done), 32'd1);
    do_req(1'b0, 3'b010, 32'h0000_03FC, '0, got);
    check_eq("cleared_word", got, 32'h0);

    do_req(1'b1, 3'b010, 32'h8, 32'h80FF_7F01, got);
    do_req(1'b0, 3'b000, 32'h8, '0, got);  check_eq("lb_8", got, 32'h0000_0001);
    do_req(1'b0, 3'b000, 32'hB, '0, got);  check_eq("lb_b", got, 32'hFFFF_FF80);
    do_req(1'b0, 3'b100, 32'hB, '0, got);  check_eq("lbu_b", got, 32'h0000_0080);
    do_req(1'b0, 3'b001, 32'hA, '0, got);  check_eq("lh_a", got, 32'hFFFF_80FF);
    do_req(1'b0, 3'b101, 32'hA, '0, got);  check_eq("lhu_a", got, 32'h0000_80FF);

    do_req(1'b1, 3'b010, 32'h10, 32'h1122_3344, got);
    do_req(1'b1, 3'b000, 32'h11, 32'h0000_00AA, got);
    do_req(1'b1, 3'b001, 32'h12, 32'h0000_BEEF, got);
    do_req(1'b0, 3'b010, 32'h10, '0, got); check_eq("merge_lw", got, 32'hBEEF_AA44);

    do_req(1'b0, 3'b010, 32'h2, '0, got);
    do_req(1'b1, 3'b001, 32'h5, 32'hFFFF_FFFF, got);
    do_req(1'b1, 3'b000, 32'h400, 32'hFFFF_FFFF, got);
    do_req(1'b0, 3'b011, 32'h10, '0, got);
    do_req(1'b0, 3'b010, 32'h4, '0, got);  check_eq("err_no_write_4", got, 32'h0);
    do_req(1'b0, 3'b010, 32'h0, '0, got);  check_eq("err_no_write_0", got, 32'h0);
    idle_cycle();

    do_req(1'b1, 3'b010, 32'h20, 32'hA5A5_A5A5, got);
    do_req(1'b0, 3'b010, 32'h20, '0, got); check_eq("b2b_lw", got, 32'hA5A5_A5A5);
    idle_cycle();

    for (int unsigned t = 0; t < 400; t++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      if (!we && $urandom_range(0, 1) == 1) f3 = {1'($urandom), 2'($urandom_range(0, 2))};
      if (we && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       addr = $urandom;
        1:       addr = $urandom_range(NBYTES - 8, NBYTES + 8);
        default: addr = $urandom_range(0, 63);
      endcase
      do_req(we, f3, addr, $urandom, got);
      if ($urandom_range(0, 9) == 0) idle_cycle();
    end

    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    release_and_count(100, n);
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_sweep_reset");
    repeat (2) @(posedge clk);
    release_and_count(0, n);
    check_eq("resweep_cycles", n, 32'd256);
    for (int unsigned i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    do_req(1'b0, 3'b010, 32'h20, '0, got); check_eq("resweep_clear", got, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
